// File: rtl/mux_pkg.sv
// Shared types for the 4:1 channel arbiter: FSM states, hold-counter width, sel mapping.
// Pure definitions, no timing or backpressure of its own.
package mux_pkg;

  localparam int unsigned MAX_HOLD_DEFAULT = 8;
  localparam int          HOLD_W           = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // The downstream mux wires its select bits swapped, so owner index is bit-reversed.
  function automatic logic [1:0] sel_map(input logic [1:0] idx);
    return {idx[0], idx[1]};
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between the requesters and the channel arbiter.
// Requesters hold req high until done; the arbiter answers with registered gnt/sel/busy.
interface mux_arbiter_if;

  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping 3->0.
// With excl_en the index just before start (the current owner) is skipped; zero latency.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic       excl_en,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && req[cand] && !(excl_en && (k == 3))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 channel with hold-limit pre-emption.
// One cycle req-to-gnt; owner released on req drop or after MAX_HOLD cycles if others wait.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  mux_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        last_q, last_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] pick_start;
  logic       pick_excl;
  logic       owner_req;

  // While owning, last_q is the owner, so starting at last_q+1 and excluding
  // the final slot covers both the idle search and the hand-over search.
  assign pick_start = last_q + 2'd1;
  assign pick_excl  = (state_q == ST_OWN);
  assign owner_req  = bus.req[last_q];

  rr_pick u_rr_pick (
    .req     (bus.req),
    .start   (pick_start),
    .excl_en (pick_excl),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWN;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = sel_map(pick_idx);
          busy_d  = 1'b1;
          hold_d  = 8'd1;
          last_d  = pick_idx;
        end
      end
      ST_OWN: begin
        if (!owner_req || (hold_q == HOLD_LIMIT)) begin
          if (pick_found) begin
            gnt_d  = 4'b0001 << pick_idx;
            sel_d  = sel_map(pick_idx);
            busy_d = 1'b1;
            hold_d = 8'd1;
            last_d = pick_idx;
          end else if (!owner_req) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed scenarios plus a long random run of mux_arbiter against a behavioural owner model.
module tb_mux_arbiter;

  localparam int MH = 8;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  mux_arbiter_if bus ();

  mux_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: owner index (-1 = none), last owner, cycles held, current select.
  int m_owner;
  int m_last;
  int m_hold;
  int m_sel;
  int rev [4];
  int wait_cnt [4];
  int max_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_grant(input int c);
    m_owner = c;
    m_last  = c;
    m_hold  = 1;
    m_sel   = rev[c];
  endtask

  task automatic model_step(input logic [3:0] r, input logic rn);
    int  c;
    bool_found: begin end
    if (!rn) begin
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (r[c]) begin
          model_grant(c);
          break;
        end
      end
    end else if (!r[m_owner] || m_hold == MH) begin
      int nxt;
      nxt = -1;
      for (int k = 1; k <= 3; k++) begin
        c = (m_owner + k) % 4;
        if (r[c] && nxt < 0) nxt = c;
      end
      if (nxt >= 0) begin
        model_grant(nxt);
      end else if (!r[m_owner]) begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else begin
      m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
    end
  endtask

  // One clock: advance the model at the edge, then compare just after it.
  task automatic tick();
    logic [3:0] exp_gnt;
    @(posedge clk);
    model_step(bus.req, rst_n);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
    for (int i = 0; i < 4; i++) begin
      if (rst_n && bus.req[i] && !bus.gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rq;
    int         idx;
    n_assert = 0;
    n_fail   = 0;
    max_wait = 0;
    rev      = '{0, 2, 1, 3};
    wait_cnt = '{0, 0, 0, 0};
    m_owner  = -1;
    m_last   = 3;
    m_hold   = 0;
    m_sel    = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // All four requesting: 8-cycle rotation 0,1,2,3,0
    bus.req = 4'b1111;
    for (int k = 0; k < 33; k++) begin
      tick();
      idx = (k / MH) % 4;
      chk("rot_gnt", 32'(bus.gnt), 32'(4'b0001 << idx));
      chk("rot_sel", 32'(bus.sel), 32'(rev[idx]));
    end

    // Lone requester keeps the channel
    do_reset();
    bus.req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("solo_gnt", 32'(bus.gnt), 32'h4);
      chk("solo_sel", 32'(bus.sel), 32'h1);
    end

    // Owner 1 drops while 3 waits: direct hand-over, busy stays high
    do_reset();
    bus.req = 4'b0010;
    tick();
    chk("own1_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1010;
    tick();
    tick();
    chk("own1_hold", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1000;
    tick();
    chk("handover_gnt", 32'(bus.gnt), 32'h8);
    chk("handover_busy", 32'(bus.busy), 32'h1);
    chk("handover_sel", 32'(bus.sel), 32'h3);

    // Owner drops with nobody else: idle, sel retained
    bus.req = 4'b0000;
    tick();
    chk("release_gnt", 32'(bus.gnt), 32'h0);
    chk("release_busy", 32'(bus.busy), 32'h0);
    chk("release_sel", 32'(bus.sel), 32'h3);
    tick();
    chk("idle_sel", 32'(bus.sel), 32'h3);

    // Reset pulse during owner 2's grant
    do_reset();
    bus.req = 4'b0100;
    tick();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0110;
    rst_n   = 1'b0;
    tick();
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(bus.gnt), 32'h2);
    chk("post_rst_sel", 32'(bus.sel), 32'h2);

    // Random sticky requests
    do_reset();
    max_wait = 0;
    rq = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      bus.req = rq;
      tick();
      chk("onehot0", 32'($onehot0(bus.gnt)), 32'h1);
    end
    chk("max_wait_ok", 32'(max_wait <= 3 * MH), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles while another requester is waiting (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  request lines; req[i] is held high by requester i while it wants the shared 4:1 channel.
REQ-005 gnt  output  4  registered one-hot grant; all zeros when no requester owns the channel.
REQ-006 sel  output  2  registered select for the 4:1 channel mux, bit-reversed index: owner 0 -> 2'b00, 1 -> 2'b10, 2 -> 2'b01, 3 -> 2'b11.
REQ-007 busy  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-008 The block SHALL implement two states: IDLE (no owner) and OWN (one owner, gnt one-hot).
REQ-009 In IDLE, if any req bit is high at a rising edge, the block SHALL enter OWN with the winner's gnt bit, sel and busy valid at that edge (1-cycle req-to-gnt latency).
REQ-010 Winner selection SHALL be round-robin: search starts at (last_owner+1) mod 4 and takes the first asserted req bit in increasing index order, wrapping 3->0.
REQ-011 last_owner SHALL update to the new owner's index on every grant.
REQ-012 In OWN, a hold counter SHALL load 1 on grant and increment each cycle the owner keeps req high, saturating at MAX_HOLD.
REQ-013 Release: if the owner's req is low at an edge, the block SHALL arbitrate at that same edge among the other requesters; if any is high, it SHALL grant one directly (no idle bubble), else return to IDLE with gnt=0, busy=0.
REQ-014 Pre-emption: if the hold counter equals MAX_HOLD and any other req bit is high, the block SHALL grant the next round-robin winner at that edge, even though the owner's req is still high.
REQ-015 With no other requester waiting, the owner SHALL keep the grant indefinitely; the counter stays saturated.
REQ-016 The round-robin search in REQ-013/REQ-014 SHALL exclude the current owner.
REQ-017 sel SHALL always match the gnt index per REQ-006; in IDLE sel SHALL hold its last value.
REQ-018 gnt SHALL never have more than one bit set, and SHALL change only on a rising edge.
REQ-019 Requesters dropping req while not granted SHALL have no effect; no request is latched.

Reset
REQ-020 While rst_n is low at a rising edge: state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, hold counter=0, last_owner=3, giving requester 0 first priority.
REQ-021 Reset asserted mid-grant SHALL drop gnt at that edge; arbitration SHALL resume at the first edge with rst_n high.

Structure
REQ-022 State encodings, the sel bit-reverse mapping function and the MAX_HOLD default SHALL live in a shared package, mux_pkg.
REQ-023 The round-robin priority search SHALL be a sub-module, rr_pick: 4-bit request, 2-bit start index and exclude enable in; found flag and 2-bit index out; purely combinational.
REQ-024 The hold counter SHALL be 8 bits wide.

Verification
REQ-025 After reset, req=4'b1111 held -> gnt 0001, then after 8 cycles 0010, then 0100, then 1000, then 0001; sel 00,10,01,11,00.
REQ-026 req=4'b0100 alone for 20 cycles -> gnt=0100, sel=01 throughout, no pre-emption.
REQ-027 Owner 1 drops req while req[3] is high -> gnt 0010 changes to 1000 at the next edge, busy stays 1.
REQ-028 Owner drops req and no one else requests -> gnt=0000, busy=0 next edge; sel retains its last value.
REQ-029 rst_n low for one cycle during owner 2's grant with req=4'b0110 -> gnt=0000, then gnt=0010 one edge after rst_n rises.
REQ-030 Random req for 10k cycles -> gnt always one-hot or zero, sel consistent with gnt, no requester waits more than 3*MAX_HOLD cycles.
